axi_wr_arbiter: RTL and testbench
=================================

# axi_wr_arbiter

- Two-requester AXI4 write-channel arbiter sharing one 64-bit master write port (AW/W/B) between two bus-master engines.
- Typical pairing: the button-triggered capture writer and a status/descriptor writer.
- Grants whole transactions round-robin, holds the grant from address acceptance through the write response, and checks beat count against AWLEN.
- Read channels are out of scope and not routed through this block.

## Interface
- ADDR_W, 32, address width
- DATA_W, 64, data width; strobe width is DATA_W/8
- M_AXI_ACLK  in  1  single clock; all logic on rising edge
- M_AXI_ARESETN  in  1  reset, asynchronous, active-low
- S_AWADDR  in  2*ADDR_W  per-requester address; requester r in bits [r*ADDR_W +: ADDR_W]
- S_AWLEN  in  16  per-requester burst length minus 1; [r*8 +: 8]
- S_AWVALID  in  2  per-requester address valid
- S_AWREADY  out  2  per-requester address accept
- S_WDATA  in  2*DATA_W  per-requester write data
- S_WSTRB  in  2*DATA_W/8  per-requester byte strobes
- S_WLAST  in  2  per-requester last beat
- S_WVALID  in  2  per-requester data valid
- S_WREADY  out  2  per-requester data ready
- S_BVALID  out  2  per-requester response valid
- S_BREADY  in  2  per-requester response ready
- M_AXI_AWADDR  out  ADDR_W  registered granted address
- M_AXI_AWLEN  out  8  registered granted length
- M_AXI_AWSIZE  out  3  constant log2(DATA_W/8) (3 for 64-bit)
- M_AXI_AWBURST  out  2  constant 2'b01 (INCR)
- M_AXI_AWPROT  out  3  constant 3'b000
- M_AXI_AWVALID  out  1  registered address valid
- M_AXI_AWREADY  in  1  slave address accept
- M_AXI_WDATA / M_AXI_WSTRB / M_AXI_WLAST  out  DATA_W / DATA_W/8 / 1  muxed from granted requester
- M_AXI_WVALID  out  1  granted requester's WVALID, state W only
- M_AXI_WREADY  in  1  slave data ready
- M_AXI_BVALID  in  1  slave response valid
- M_AXI_BREADY  out  1  granted requester's BREADY, state B only
- len_err  out  1  sticky: WLAST did not coincide with beat AWLEN+1

## Operation
- State machine IDLE -> AW -> W -> B -> IDLE. Registers:
  - gnt (1 bit): granted requester
  - prio (1 bit): preferred requester
  - beat counter (8 bits)
- IDLE:
  - sel = prio if S_AWVALID[prio], else the other requester if its AWVALID is set.
  - S_AWREADY[sel] = 1 combinationally.
  - On that handshake: latch gnt=sel, M_AXI_AWADDR/AWLEN from the requester, set M_AXI_AWVALID=1, clear beat counter, go to AW.
- AW: hold M_AXI_AWVALID and address/length stable. On M_AXI_AWREADY, clear AWVALID and go to W.
- W:
  - M_AXI_W* = S_W*[gnt]; S_WREADY[gnt] = M_AXI_WREADY.
  - Each M-side W handshake increments the beat counter.
  - Handshake with WLAST goes to B.
  - len_err sets if the WLAST beat index differs from AWLEN, or if beat AWLEN+1 completes without WLAST. In the latter case the block keeps passing beats until WLAST.
- B: S_BVALID[gnt] = M_AXI_BVALID; M_AXI_BREADY = S_BREADY[gnt]. On handshake, prio = ~gnt, go to IDLE.
- Non-granted requester: all its readies and BVALID are 0. Its pending AWVALID waits.
- Outside state W, M_AXI_WVALID is 0. Outside state B, M_AXI_BREADY is 0.

## Timing
- Reset: state IDLE, gnt=0, prio=0, M_AXI_AWVALID=0, M_AXI_AWADDR=0, M_AXI_AWLEN=0, len_err=0.
  - All combinational outputs are 0 in IDLE except S_AWREADY.
- Reset mid-transaction aborts immediately to these values; no completion is generated.
- Latency:
  - S_AWVALID in IDLE at cycle k -> S_AWREADY in cycle k.
  - M_AXI_AWVALID high from cycle k+1.
  - W enabled the cycle after the M AW handshake.
  - B handshake at cycle n -> IDLE at n+1; the next grant can be accepted at n+1.
- Simultaneous AWVALID from both requesters: prio wins; the loser is granted next.
- A single active requester is granted regardless of prio.
- AW stays asserted across any number of AWREADY-low cycles; address and length are stable while AWVALID is high.
- Data is combinational pass-through: no W buffering, zero added W latency.
- Beat counter wraps are irrelevant; AWLEN ≤ 255 bounds it.

## Test plan
- Reset, then only requester 0 requests 0x1000 with AWLEN=3; slave always ready -> M_AXI_AWADDR=0x1000, AWLEN=3, exactly 4 W beats, one B handshake, len_err=0.
- Both requesters assert AWVALID in the same cycle after reset -> requester 0 granted first, requester 1 second, prio=0 afterwards; S_WREADY[1] stays 0 throughout grant 0.
- Slave AWREADY pattern 1,1,1,0 and WREADY pattern 1,1,1,1,1,0; three back-to-back 8-beat bursts -> three AW handshakes, 24 W handshakes, data order preserved, no beat dropped.
- AWLEN=3 with WLAST on beat 2 -> len_err=1 and sticky, transaction still proceeds to B; a second case with WLAST on beat 5 -> len_err=1.
- Assert M_AXI_ARESETN low during state W -> all outputs at reset values that cycle; the next request is granted normally with len_err=0.
- Requester 1 holds AWVALID continuously while requester 0 issues repeated bursts -> grants alternate 0,1,0,1; no starvation.

Source files
------------

// File: rtl/axi_wr_arbiter.sv
// -----------------------------------------------------------------------------
// axi_wr_arbiter
//
// Shares one AXI4 master write port (AW/W/B) between two write requesters.
// Whole transactions are granted round-robin: a grant is taken when the
// requester's address is accepted and held until its write response has been
// handed back. The granted AW is registered toward the slave. W and B are
// combinational pass-through, so no data is buffered. The block also counts
// W beats against AWLEN and raises a sticky length-error flag on a mismatch.
//
// Ports
//   M_AXI_ACLK, M_AXI_ARESETN   clock, asynchronous active-low reset
//   S_AW*  (x2)                 per-requester address channel; requester r
//                               uses slice [r*W +: W] of each packed bus
//   S_W*   (x2)                 per-requester write-data channel
//   S_B*   (x2)                 per-requester write-response handshake
//   M_AXI_AW*                   registered address channel to the slave
//   M_AXI_W*                    write data muxed from the granted requester
//   M_AXI_B*                    write-response handshake from the slave
//   len_err                     sticky: WLAST did not land on beat AWLEN+1
// -----------------------------------------------------------------------------
module axi_wr_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 64
) (
  input  logic                    M_AXI_ACLK,
  input  logic                    M_AXI_ARESETN,
  // requester side
  input  logic [2*ADDR_W-1:0]     S_AWADDR,
  input  logic [15:0]             S_AWLEN,
  input  logic [1:0]              S_AWVALID,
  output logic [1:0]              S_AWREADY,
  input  logic [2*DATA_W-1:0]     S_WDATA,
  input  logic [2*DATA_W/8-1:0]   S_WSTRB,
  input  logic [1:0]              S_WLAST,
  input  logic [1:0]              S_WVALID,
  output logic [1:0]              S_WREADY,
  output logic [1:0]              S_BVALID,
  input  logic [1:0]              S_BREADY,
  // master side
  output logic [ADDR_W-1:0]       M_AXI_AWADDR,
  output logic [7:0]              M_AXI_AWLEN,
  output logic [2:0]              M_AXI_AWSIZE,
  output logic [1:0]              M_AXI_AWBURST,
  output logic [2:0]              M_AXI_AWPROT,
  output logic                    M_AXI_AWVALID,
  input  logic                    M_AXI_AWREADY,
  output logic [DATA_W-1:0]       M_AXI_WDATA,
  output logic [DATA_W/8-1:0]     M_AXI_WSTRB,
  output logic                    M_AXI_WLAST,
  output logic                    M_AXI_WVALID,
  input  logic                    M_AXI_WREADY,
  input  logic                    M_AXI_BVALID,
  output logic                    M_AXI_BREADY,
  output logic                    len_err
);

  localparam int STRB_W = DATA_W / 8;
  localparam logic [2:0] AW_SIZE = 3'($clog2(STRB_W));

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_AW,
    ST_W,
    ST_B
  } state_e;

  state_e              state_q,   state_d;
  logic                gnt_q,     gnt_d;
  logic                prio_q,    prio_d;
  logic [7:0]          beat_q,    beat_d;
  logic [ADDR_W-1:0]   awaddr_q,  awaddr_d;
  logic [7:0]          awlen_q,   awlen_d;
  logic                awvalid_q, awvalid_d;
  logic                len_err_q, len_err_d;

  logic                sel;
  // granted requester's W/B signals
  logic [DATA_W-1:0]   g_wdata;
  logic [STRB_W-1:0]   g_wstrb;
  logic                g_wlast;
  logic                g_wvalid;
  logic                g_bready;

  assign g_wdata  = gnt_q ? S_WDATA[DATA_W +: DATA_W] : S_WDATA[0 +: DATA_W];
  assign g_wstrb  = gnt_q ? S_WSTRB[STRB_W +: STRB_W] : S_WSTRB[0 +: STRB_W];
  assign g_wlast  = S_WLAST[gnt_q];
  assign g_wvalid = S_WVALID[gnt_q];
  assign g_bready = S_BREADY[gnt_q];

  // The preferred requester wins; otherwise whoever is asking.
  assign sel = S_AWVALID[prio_q] ? prio_q : ~prio_q;

  // NOTE: every signal written below gets a default first, so no path through
  // the case statement leaves a value unassigned and no latch is inferred.
  always_comb begin
    state_d       = state_q;
    gnt_d         = gnt_q;
    prio_d        = prio_q;
    beat_d        = beat_q;
    awaddr_d      = awaddr_q;
    awlen_d       = awlen_q;
    awvalid_d     = awvalid_q;
    len_err_d     = len_err_q;
    S_AWREADY     = '0;
    S_WREADY      = '0;
    S_BVALID      = '0;
    M_AXI_WDATA   = '0;
    M_AXI_WSTRB   = '0;
    M_AXI_WLAST   = 1'b0;
    M_AXI_WVALID  = 1'b0;
    M_AXI_BREADY  = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (|S_AWVALID) begin
          S_AWREADY[sel] = 1'b1;
          gnt_d          = sel;
          awaddr_d       = sel ? S_AWADDR[ADDR_W +: ADDR_W] : S_AWADDR[0 +: ADDR_W];
          awlen_d        = sel ? S_AWLEN[15:8] : S_AWLEN[7:0];
          awvalid_d      = 1'b1;
          beat_d         = '0;
          state_d        = ST_AW;
        end
      end

      ST_AW: begin
        if (M_AXI_AWREADY) begin
          awvalid_d = 1'b0;
          state_d   = ST_W;
        end
      end

      ST_W: begin
        M_AXI_WDATA     = g_wdata;
        M_AXI_WSTRB     = g_wstrb;
        M_AXI_WLAST     = g_wlast;
        M_AXI_WVALID    = g_wvalid;
        S_WREADY[gnt_q] = M_AXI_WREADY;
        if (g_wvalid && M_AXI_WREADY) begin
          beat_d = beat_q + 8'd1;
          // beat_q is the zero-based index of the beat completing now.
          if (g_wlast) begin
            if (beat_q != awlen_q) len_err_d = 1'b1;
            state_d = ST_B;
          end else if (beat_q == awlen_q) begin
            // Burst overran AWLEN; keep forwarding until the requester's WLAST.
            len_err_d = 1'b1;
          end
        end
      end

      ST_B: begin
        S_BVALID[gnt_q] = M_AXI_BVALID;
        M_AXI_BREADY    = g_bready;
        if (M_AXI_BVALID && g_bready) begin
          prio_d  = ~gnt_q;
          state_d = ST_IDLE;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: the reset is asynchronous so a reset mid-transaction drops the grant
  // and every registered output immediately, without waiting for a clock.
  always_ff @(posedge M_AXI_ACLK or negedge M_AXI_ARESETN) begin
    if (!M_AXI_ARESETN) begin
      state_q   <= ST_IDLE;
      gnt_q     <= 1'b0;
      prio_q    <= 1'b0;
      beat_q    <= '0;
      awaddr_q  <= '0;
      awlen_q   <= '0;
      awvalid_q <= 1'b0;
      len_err_q <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments make all registers update together from
      // the values computed in the combinational block, independent of order.
      state_q   <= state_d;
      gnt_q     <= gnt_d;
      prio_q    <= prio_d;
      beat_q    <= beat_d;
      awaddr_q  <= awaddr_d;
      awlen_q   <= awlen_d;
      awvalid_q <= awvalid_d;
      len_err_q <= len_err_d;
    end
  end

  assign M_AXI_AWADDR  = awaddr_q;
  assign M_AXI_AWLEN   = awlen_q;
  assign M_AXI_AWVALID = awvalid_q;
  assign M_AXI_AWSIZE  = AW_SIZE;
  assign M_AXI_AWBURST = 2'b01;
  assign M_AXI_AWPROT  = 3'b000;
  assign len_err       = len_err_q;

endmodule

// File: tb/tb_axi_wr_arbiter.sv
// -----------------------------------------------------------------------------
// tb_axi_wr_arbiter
//
// Scoreboard bench for axi_wr_arbiter. Requester tasks push the expected
// grant, address, data beats and response owner as they issue stimulus; a
// monitor process pops and compares whenever a handshake appears. A small
// slave model drives AWREADY/WREADY from rotating patterns and answers each
// WLAST with one BVALID.
// -----------------------------------------------------------------------------
module tb_axi_wr_arbiter;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 64;
  localparam int STRB_W = DATA_W / 8;

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic [STRB_W-1:0] strb;
    logic              last;
  } w_beat_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // DUT ports
  logic [2*ADDR_W-1:0]   s_awaddr;
  logic [15:0]           s_awlen;
  logic [1:0]            s_awvalid, s_awready;
  logic [2*DATA_W-1:0]   s_wdata;
  logic [2*STRB_W-1:0]   s_wstrb;
  logic [1:0]            s_wlast, s_wvalid, s_wready;
  logic [1:0]            s_bvalid, s_bready;
  logic [ADDR_W-1:0]     m_awaddr;
  logic [7:0]            m_awlen;
  logic [2:0]            m_awsize, m_awprot;
  logic [1:0]            m_awburst;
  logic                  m_awvalid, m_awready;
  logic [DATA_W-1:0]     m_wdata;
  logic [STRB_W-1:0]     m_wstrb;
  logic                  m_wlast, m_wvalid, m_wready;
  logic                  m_bvalid, m_bready;
  logic                  len_err;

  // per-requester drive state
  logic [ADDR_W-1:0] rq_awaddr  [2];
  logic [7:0]        rq_awlen   [2];
  logic              rq_awvalid [2];
  logic [DATA_W-1:0] rq_wdata   [2];
  logic [STRB_W-1:0] rq_wstrb   [2];
  logic              rq_wlast   [2];
  logic              rq_wvalid  [2];
  logic              rq_bready  [2];

  assign s_awaddr  = {rq_awaddr[1],  rq_awaddr[0]};
  assign s_awlen   = {rq_awlen[1],   rq_awlen[0]};
  assign s_awvalid = {rq_awvalid[1], rq_awvalid[0]};
  assign s_wdata   = {rq_wdata[1],   rq_wdata[0]};
  assign s_wstrb   = {rq_wstrb[1],   rq_wstrb[0]};
  assign s_wlast   = {rq_wlast[1],   rq_wlast[0]};
  assign s_wvalid  = {rq_wvalid[1],  rq_wvalid[0]};
  assign s_bready  = {rq_bready[1],  rq_bready[0]};

  axi_wr_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .M_AXI_ACLK    (clk),
    .M_AXI_ARESETN (rst_n),
    .S_AWADDR      (s_awaddr),
    .S_AWLEN       (s_awlen),
    .S_AWVALID     (s_awvalid),
    .S_AWREADY     (s_awready),
    .S_WDATA       (s_wdata),
    .S_WSTRB       (s_wstrb),
    .S_WLAST       (s_wlast),
    .S_WVALID      (s_wvalid),
    .S_WREADY      (s_wready),
    .S_BVALID      (s_bvalid),
    .S_BREADY      (s_bready),
    .M_AXI_AWADDR  (m_awaddr),
    .M_AXI_AWLEN   (m_awlen),
    .M_AXI_AWSIZE  (m_awsize),
    .M_AXI_AWBURST (m_awburst),
    .M_AXI_AWPROT  (m_awprot),
    .M_AXI_AWVALID (m_awvalid),
    .M_AXI_AWREADY (m_awready),
    .M_AXI_WDATA   (m_wdata),
    .M_AXI_WSTRB   (m_wstrb),
    .M_AXI_WLAST   (m_wlast),
    .M_AXI_WVALID  (m_wvalid),
    .M_AXI_WREADY  (m_wready),
    .M_AXI_BVALID  (m_bvalid),
    .M_AXI_BREADY  (m_bready),
    .len_err       (len_err)
  );

  // scoreboard
  int                 exp_gnt [$];
  logic [39:0]        exp_aw  [$];
  w_beat_t            exp_w   [$];
  int                 exp_b   [$];
  int                 cur_owner = 0;
  int                 aw_cnt = 0, w_cnt = 0, b_cnt = 0;
  int                 n_checks = 0, n_pass = 0;

  // slave ready patterns, bit i used in rotation step i
  logic [3:0]         aw_pat = 4'hF;
  logic [5:0]         w_pat  = 6'h3F;

  task automatic check(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
  endtask

  task automatic fail_msg(input string nm, input string msg);
    n_checks++;
    $display("FAIL %s: %s", nm, msg);
  endtask

  function automatic w_beat_t make_beat(input int r, input logic [31:0] addr,
                                        input int i, input int nbeats);
    w_beat_t b;
    b.data = {addr, 8'(r), 8'h5A, 16'(i)};
    b.strb = 8'hFF ^ 8'(i);
    b.last = (i == nbeats);
    return b;
  endfunction

  // kind 0: AWREADY, 1: WREADY, 2: BVALID on requester r. Returns at posedge+1.
  task automatic wait_hs(input int r, input int kind);
    bit seen = 1'b0;
    for (int c = 0; c < 500; c++) begin
      @(negedge clk);
      if ((kind == 0 && s_awready[r]) || (kind == 1 && s_wready[r]) ||
          (kind == 2 && s_bvalid[r])) begin
        seen = 1'b1;
        break;
      end
    end
    if (!seen) fail_msg("handshake_wait", $sformatf("requester %0d kind %0d timed out", r, kind));
    @(posedge clk);
    #1;
  endtask

  task automatic drive_beat(input int r, input w_beat_t b);
    rq_wdata[r]  = b.data;
    rq_wstrb[r]  = b.strb;
    rq_wlast[r]  = b.last;
    rq_wvalid[r] = 1'b1;
  endtask

  // One full write transaction; WLAST rides on the final beat issued.
  task automatic do_burst(input int r, input logic [31:0] addr, input logic [7:0] len,
                          input int nbeats);
    w_beat_t b;
    rq_awaddr[r]  = addr;
    rq_awlen[r]   = len;
    rq_awvalid[r] = 1'b1;
    wait_hs(r, 0);
    rq_awvalid[r] = 1'b0;
    exp_aw.push_back({addr, len});
    for (int i = 1; i <= nbeats; i++) begin
      b = make_beat(r, addr, i, nbeats);
      drive_beat(r, b);
      exp_w.push_back(b);
      wait_hs(r, 1);
    end
    rq_wvalid[r] = 1'b0;
    rq_wlast[r]  = 1'b0;
    rq_bready[r] = 1'b1;
    exp_b.push_back(r);
    wait_hs(r, 2);
    rq_bready[r] = 1'b0;
  endtask

  // Requester inputs must be idle when this is called.
  task automatic check_reset_outputs(input string tag);
    check({tag, "_awvalid"}, m_awvalid, 0);
    check({tag, "_awaddr"},  m_awaddr,  0);
    check({tag, "_awlen"},   m_awlen,   0);
    check({tag, "_len_err"}, len_err,   0);
    check({tag, "_wvalid"},  m_wvalid,  0);
    check({tag, "_bready"},  m_bready,  0);
    check({tag, "_s_wready"}, s_wready, 0);
    check({tag, "_s_bvalid"}, s_bvalid, 0);
  endtask

  task automatic pulse_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check_reset_outputs("pulse_rst");
    check("pulse_rst_awready", s_awready, 0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  // slave model
  initial begin
    bit wl, bh;
    int aw_i = 0, w_i = 0;
    m_awready = 1'b0;
    m_wready  = 1'b0;
    m_bvalid  = 1'b0;
    forever begin
      @(negedge clk);
      wl = m_wvalid && m_wready && m_wlast;
      bh = m_bvalid && m_bready;
      @(posedge clk);
      #1;
      if (!rst_n) m_bvalid = 1'b0;
      else begin
        if (bh) m_bvalid = 1'b0;
        if (wl) m_bvalid = 1'b1;
      end
      m_awready = aw_pat[aw_i];
      aw_i      = (aw_i + 1) % 4;
      m_wready  = w_pat[w_i];
      w_i       = (w_i + 1) % 6;
    end
  end

  // monitor: pops the scoreboard on every observed handshake
  initial begin
    logic [39:0] ea;
    w_beat_t     ew;
    int          eg;
    logic [1:0]  owner_mask;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        for (int r = 0; r < 2; r++) begin
          if (s_awvalid[r] && s_awready[r]) begin
            if (exp_gnt.size() == 0) fail_msg("grant", $sformatf("unexpected grant to %0d", r));
            else begin
              eg = exp_gnt.pop_front();
              check("grant_req", r, eg);
              cur_owner = eg;
            end
          end
        end
        if (m_awvalid && m_awready) begin
          aw_cnt++;
          if (exp_aw.size() == 0) fail_msg("aw", "unexpected AW handshake");
          else begin
            ea = exp_aw.pop_front();
            check("aw_addr", m_awaddr, ea[39:8]);
            check("aw_len",  m_awlen,  ea[7:0]);
          end
        end
        if (m_wvalid && m_wready) begin
          w_cnt++;
          owner_mask = 2'b01 << cur_owner;
          check("w_ready_owner", s_wready, owner_mask);
          if (exp_w.size() == 0) fail_msg("w", "unexpected W handshake");
          else begin
            ew = exp_w.pop_front();
            check("w_data", m_wdata, ew.data);
            check("w_strb", m_wstrb, ew.strb);
            check("w_last", m_wlast, ew.last);
          end
        end
        if (m_bvalid && m_bready) begin
          b_cnt++;
          if (exp_b.size() == 0) fail_msg("b", "unexpected B handshake");
          else begin
            eg = exp_b.pop_front();
            owner_mask = 2'b01 << eg;
            check("b_owner", s_bvalid, owner_mask);
          end
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  // stimulus
  initial begin
    int aw0, w0, b0;
    w_beat_t bt;
    for (int r = 0; r < 2; r++) begin
      rq_awaddr[r] = '0; rq_awlen[r] = '0; rq_awvalid[r] = 1'b0;
      rq_wdata[r]  = '0; rq_wstrb[r] = '0; rq_wlast[r]   = 1'b0;
      rq_wvalid[r] = 1'b0; rq_bready[r] = 1'b0;
    end
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    check("reset_awready", s_awready, 0);
    check("awsize",  m_awsize,  3);
    check("awburst", m_awburst, 1);
    check("awprot",  m_awprot,  0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // single requester, 4-beat burst
    exp_gnt.push_back(0);
    do_burst(0, 32'h1000, 8'd3, 4);
    check("t1_aw_cnt", aw_cnt, 1);
    check("t1_w_cnt",  w_cnt,  4);
    check("t1_b_cnt",  b_cnt,  1);
    check("t1_len_err", len_err, 0);

    // simultaneous requests after reset: 0 then 1, and again 0 then 1
    pulse_reset();
    exp_gnt.push_back(0); exp_gnt.push_back(1);
    fork
      do_burst(0, 32'h2000, 8'd1, 2);
      do_burst(1, 32'h3000, 8'd2, 3);
    join
    exp_gnt.push_back(0); exp_gnt.push_back(1);
    fork
      do_burst(0, 32'h2100, 8'd0, 1);
      do_burst(1, 32'h3100, 8'd0, 1);
    join

    // stalling slave, three back-to-back 8-beat bursts
    aw_pat = 4'b0111;
    w_pat  = 6'b011111;
    aw0 = aw_cnt; w0 = w_cnt; b0 = b_cnt;
    for (int k = 0; k < 3; k++) begin
      exp_gnt.push_back(0);
      do_burst(0, 32'h4000 + 32'(k * 64), 8'd7, 8);
    end
    check("t3_aw_cnt", aw_cnt - aw0, 3);
    check("t3_w_cnt",  w_cnt - w0,  24);
    check("t3_b_cnt",  b_cnt - b0,  3);
    check("t3_len_err", len_err, 0);
    aw_pat = 4'hF;
    w_pat  = 6'h3F;

    // short burst: WLAST on beat 2 of 4, then a clean burst (sticky)
    exp_gnt.push_back(0);
    do_burst(0, 32'h5000, 8'd3, 2);
    check("t4_short_len_err", len_err, 1);
    exp_gnt.push_back(1);
    do_burst(1, 32'h5100, 8'd3, 4);
    check("t4_sticky_len_err", len_err, 1);
    // long burst: WLAST on beat 5 of 4
    pulse_reset();
    exp_gnt.push_back(0);
    do_burst(0, 32'h6000, 8'd3, 5);
    check("t4_long_len_err", len_err, 1);

    // reset during the data phase
    pulse_reset();
    exp_gnt.push_back(0);
    rq_awaddr[0] = 32'h7000; rq_awlen[0] = 8'd3; rq_awvalid[0] = 1'b1;
    wait_hs(0, 0);
    rq_awvalid[0] = 1'b0;
    exp_aw.push_back({32'h7000, 8'd3});
    bt = make_beat(0, 32'h7000, 1, 4);
    drive_beat(0, bt);
    exp_w.push_back(bt);
    wait_hs(0, 1);
    bt = make_beat(0, 32'h7000, 2, 4);
    drive_beat(0, bt);
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_outputs("midw_rst");
    check("midw_rst_awready", s_awready, 0);
    @(posedge clk);
    #1;
    rq_wvalid[0] = 1'b0;
    rq_wlast[0]  = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    b0 = b_cnt;
    exp_gnt.push_back(0);
    do_burst(0, 32'h8000, 8'd3, 4);
    check("t5_len_err", len_err, 0);
    check("t5_b_cnt", b_cnt - b0, 1);

    // requester 1 keeps asking while requester 0 repeats: 0,1,0,1
    pulse_reset();
    exp_gnt.push_back(0); exp_gnt.push_back(1);
    exp_gnt.push_back(0); exp_gnt.push_back(1);
    fork
      begin
        do_burst(0, 32'h9000, 8'd1, 2);
        do_burst(0, 32'h9100, 8'd1, 2);
      end
      begin
        do_burst(1, 32'hA000, 8'd0, 1);
        do_burst(1, 32'hA100, 8'd0, 1);
      end
    join
    repeat (2) @(posedge clk);
    #1;
    check("end_gnt_q",  exp_gnt.size(), 0);
    check("end_aw_q",   exp_aw.size(),  0);
    check("end_w_q",    exp_w.size(),   0);
    check("end_b_q",    exp_b.size(),   0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
